// File: rtl/fcart_pkg.sv
// Shared cartridge types: PRG port FSM states and SDRAM byte-enable encodings.
package fcart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETTLE,
    ST_REQ,
    ST_RD_WAIT,
    ST_HOLD
  } prg_port_state_t;

  localparam logic [1:0] WMASK_LO = 2'b01;
  localparam logic [1:0] WMASK_HI = 2'b10;

  // Byte address bit 0 selects which half of the 16-bit SDRAM word is addressed.
  function automatic logic [1:0] byte_mask(input logic lsb);
    return lsb ? WMASK_HI : WMASK_LO;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous level, with one-clk rise/fall pulses.
// Level appears STAGES clks after the pin; edge pulses are decoded from the last two stages.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/prg_sdram_port.sv
// Bridges asynchronous CPU oe/we strobes to exactly one SDRAM word access per strobe.
// Read byte lands in data_out 1 clk after ram_rvalid; ram_req is held until ram_ack.
module prg_sdram_port #(
  parameter int ADDR_BITS   = 23,
  parameter int SYNC_STAGES = 2,
  parameter int WR_SETTLE   = 3
) (
  input  logic                 clk,
  input  logic                 cpu_reset,
  input  logic                 m2,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic                 oe,
  input  logic                 we,
  output logic                 refresh,
  output logic                 ram_req,
  output logic                 ram_we,
  output logic [ADDR_BITS-2:0] ram_addr,
  output logic [1:0]           ram_wmask,
  output logic [15:0]          ram_wdata,
  input  logic                 ram_ack,
  input  logic [15:0]          ram_rdata,
  input  logic                 ram_rvalid
);
  import fcart_pkg::*;

  localparam int CNT_W = (WR_SETTLE > 1) ? $clog2(WR_SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(WR_SETTLE - 1);

  logic oe_s, oe_rise, oe_fall;
  logic we_s, we_rise, we_fall;
  logic m2_s, m2_rise, m2_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
    .clk(clk), .rst(cpu_reset), .d(oe), .level(oe_s), .rise(oe_rise), .fall(oe_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_we (
    .clk(clk), .rst(cpu_reset), .d(we), .level(we_s), .rise(we_rise), .fall(we_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_m2 (
    .clk(clk), .rst(cpu_reset), .d(m2), .level(m2_s), .rise(m2_rise), .fall(m2_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, oe_fall, we_fall, m2_s, m2_rise};

  prg_port_state_t         state_q;
  logic [CNT_W-1:0]        settle_cnt_q;
  logic                    lsb_q;
  logic                    ram_req_q;
  logic                    ram_we_q;
  logic [ADDR_BITS-2:0]    ram_addr_q;
  logic [1:0]              ram_wmask_q;
  logic [15:0]             ram_wdata_q;
  logic [7:0]              data_out_q;

  // A simultaneous we/oe rise is treated as a write only; the read is dropped.
  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      lsb_q        <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wmask_q  <= 2'b00;
      ram_wdata_q  <= 16'h0000;
      data_out_q   <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (we_rise) begin
            ram_addr_q   <= addr[ADDR_BITS-1:1];
            lsb_q        <= addr[0];
            settle_cnt_q <= '0;
            state_q      <= ST_WR_SETTLE;
          end else if (oe_rise) begin
            ram_addr_q  <= addr[ADDR_BITS-1:1];
            lsb_q       <= addr[0];
            ram_we_q    <= 1'b0;
            ram_wmask_q <= byte_mask(addr[0]);
            ram_req_q   <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        // CPU write data is only valid late in M2 high, so sample it after a fixed settle.
        ST_WR_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            ram_wdata_q <= {data_in, data_in};
            ram_we_q    <= 1'b1;
            ram_wmask_q <= byte_mask(lsb_q);
            ram_req_q   <= 1'b1;
            state_q     <= ST_REQ;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        ST_REQ: begin
          if (ram_ack) begin
            ram_req_q <= 1'b0;
            state_q   <= ram_we_q ? ST_HOLD : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (ram_rvalid) begin
            data_out_q <= lsb_q ? ram_rdata[15:8] : ram_rdata[7:0];
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!oe_s && !we_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic ref_pend_q;
  logic ref_pend_d;
  logic refresh_ok;

  // Refresh only slips into bus-idle windows: no request outstanding and no read in flight.
  always_comb begin
    refresh_ok = ((state_q == ST_IDLE) || (state_q == ST_HOLD)) && !ram_req_q;
    ref_pend_d = m2_fall | (ref_pend_q & ~refresh_ok);
  end

  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      ref_pend_q <= 1'b0;
    end else begin
      ref_pend_q <= ref_pend_d;
    end
  end

  assign refresh   = ref_pend_q & refresh_ok;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wmask = ram_wmask_q;
  assign ram_wdata = ram_wdata_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_prg_sdram_port.sv
// Directed bench for prg_sdram_port: SDRAM responder plus a transaction-level model checked every cycle.
module tb_prg_sdram_port;
  localparam int AB = 23;

  logic          clk = 1'b0;
  logic          cpu_reset = 1'b1;
  logic          m2 = 1'b0;
  logic          oe = 1'b0;
  logic          we = 1'b0;
  logic [AB-1:0] addr = '0;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    data_out;
  logic          refresh;
  logic          ram_req;
  logic          ram_we;
  logic [AB-2:0] ram_addr;
  logic [1:0]    ram_wmask;
  logic [15:0]   ram_wdata;
  logic          ram_ack = 1'b0;
  logic [15:0]   ram_rdata = 16'h0000;
  logic          ram_rvalid = 1'b0;

  always #5 clk = ~clk;

  prg_sdram_port #(.ADDR_BITS(AB), .SYNC_STAGES(2), .WR_SETTLE(3)) dut (
    .clk(clk), .cpu_reset(cpu_reset), .m2(m2), .addr(addr), .data_in(data_in),
    .data_out(data_out), .oe(oe), .we(we), .refresh(refresh), .ram_req(ram_req),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid)
  );

  typedef struct {
    logic          we;
    logic [AB-2:0] waddr;
    logic [1:0]    wmask;
    logic [15:0]   wdata;
    logic          lsb;
  } txn_t;

  // Expected transactions: written by the stimulus process, consumed by the monitor.
  txn_t exp_tab [0:15];
  int   wr_idx = 0;

  // Responder / end-check configuration, written only by the stimulus process.
  int          ack_dly = 0;
  int          rv_dly = 1;
  logic [15:0] rdata_cfg = 16'h0000;
  logic        auto_ack = 1'b1;
  int          stray_req = 0;
  int          end_req = 0;
  string       tag = "reset";
  logic [7:0]  e_dout;
  int          e_ref;
  int          e_ntx;
  logic        e_use_ram;
  logic [AB-2:0] e_addr;
  logic [1:0]  e_mask;
  logic        e_we;
  logic [15:0] e_wdata;

  // Monitor/model state, written only by the negedge process.
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rd_idx = 0;
  int          stray_done = 0;
  int          end_done = 0;
  int          ack_wait = 0;
  int          rv_cnt = 0;
  logic        rv_armed = 1'b0;
  logic        rd_pend = 1'b0;
  logic        rd_lsb = 1'b0;
  logic [7:0]  exp_dout = 8'h00;
  int          acc_cnt = 0;
  int          ref_cnt = 0;
  logic        ref_prev = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_we = 1'b0;
  logic [AB-2:0] prev_addr = '0;
  logic [1:0]  prev_mask = 2'b00;

  function automatic txn_t mk_txn(input logic is_wr, input logic [AB-1:0] a, input logic [7:0] d);
    txn_t t;
    t.we    = is_wr;
    t.waddr = a[AB-1:1];
    t.wmask = a[0] ? 2'b10 : 2'b01;
    t.wdata = {d, d};
    t.lsb   = a[0];
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s/%s: got 0x%0h, want 0x%0h at %0t", tag, nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    txn_t e;
    logic ack_was;
    ack_was = ram_ack;
    if (cpu_reset) begin
      ram_ack = 1'b0;
      ram_rvalid = 1'b0;
      rv_armed = 1'b0;
      rd_pend = 1'b0;
      exp_dout = 8'h00;
      rd_idx = wr_idx;
      ack_wait = 0;
      chk("rst_req", 32'(ram_req), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_mask", 32'(ram_wmask), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_wdata", 32'(ram_wdata), 32'd0);
      chk("rst_refresh", 32'(refresh), 32'd0);
    end else begin
      // Read data sampled by the DUT at the last edge retires the outstanding read.
      if (ram_rvalid) begin
        if (rd_pend) begin
          exp_dout = rd_lsb ? ram_rdata[15:8] : ram_rdata[7:0];
          rd_pend = 1'b0;
        end
        ram_rvalid = 1'b0;
      end
      if (rv_armed) begin
        rv_cnt = rv_cnt - 1;
        if (rv_cnt <= 0) begin
          ram_rvalid = 1'b1;
          ram_rdata = rdata_cfg;
          rv_armed = 1'b0;
        end
      end else if (stray_req != stray_done) begin
        ram_rvalid = 1'b1;
        ram_rdata = 16'hFFFF;
        stray_done = stray_done + 1;
      end
      if (ram_ack) begin
        ram_ack = 1'b0;
      end else if (ram_req && auto_ack) begin
        if (ack_wait >= ack_dly) begin
          ram_ack = 1'b1;
          ack_wait = 0;
          chk("req_expected", 32'(wr_idx - rd_idx > 0), 32'd1);
          if (wr_idx > rd_idx) begin
            e = exp_tab[rd_idx % 16];
            rd_idx = rd_idx + 1;
            acc_cnt = acc_cnt + 1;
            chk("txn_we", 32'(ram_we), 32'(e.we));
            chk("txn_addr", 32'(ram_addr), 32'(e.waddr));
            chk("txn_mask", 32'(ram_wmask), 32'(e.wmask));
            if (e.we) chk("txn_wdata", 32'(ram_wdata), 32'(e.wdata));
            if (!e.we) begin
              rd_pend = 1'b1;
              rd_lsb = e.lsb;
              rv_armed = 1'b1;
              rv_cnt = rv_dly;
            end
          end
        end else begin
          ack_wait = ack_wait + 1;
        end
      end else begin
        ack_wait = 0;
      end
      // A pending request must keep its fields stable and may only drop after an ack.
      if (prev_req) begin
        if (ram_req) begin
          chk("hold_addr", 32'(ram_addr), 32'(prev_addr));
          chk("hold_we", 32'(ram_we), 32'(prev_we));
          chk("hold_mask", 32'(ram_wmask), 32'(prev_mask));
        end else if (!ack_was) begin
          chk("req_held", 32'(ram_req), 32'd1);
        end
      end
      if (refresh) begin
        ref_cnt = ref_cnt + 1;
        chk("ref_no_req", 32'(ram_req), 32'd0);
        chk("ref_no_rdwait", 32'(rd_pend), 32'd0);
        chk("ref_width", 32'(ref_prev), 32'd0);
      end
    end
    chk("data_out", 32'(data_out), 32'(exp_dout));
    if (end_req != end_done) begin
      chk("txn_cnt", 32'(acc_cnt), 32'(e_ntx));
      chk("txn_left", 32'(wr_idx - rd_idx), 32'd0);
      chk("refresh_cnt", 32'(ref_cnt), 32'(e_ref));
      chk("dout_model", 32'(exp_dout), 32'(e_dout));
      chk("dout_final", 32'(data_out), 32'(e_dout));
      if (e_use_ram) begin
        chk("ram_addr_final", 32'(ram_addr), 32'(e_addr));
        chk("ram_mask_final", 32'(ram_wmask), 32'(e_mask));
        chk("ram_we_final", 32'(ram_we), 32'(e_we));
        if (e_we) chk("ram_wdata_final", 32'(ram_wdata), 32'(e_wdata));
      end
      acc_cnt = 0;
      ref_cnt = 0;
      end_done = end_done + 1;
    end
    ref_prev  = cpu_reset ? 1'b0 : refresh;
    prev_req  = cpu_reset ? 1'b0 : ram_req;
    prev_we   = ram_we;
    prev_addr = ram_addr;
    prev_mask = ram_wmask;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input txn_t t);
    exp_tab[wr_idx % 16] = t;
    wr_idx = wr_idx + 1;
  endtask

  task automatic end_check(input logic [7:0] dout, input int nref, input int ntx,
                           input logic use_ram, input logic [AB-2:0] a, input logic [1:0] mask,
                           input logic w, input logic [15:0] wd);
    e_dout = dout; e_ref = nref; e_ntx = ntx; e_use_ram = use_ram;
    e_addr = a; e_mask = mask; e_we = w; e_wdata = wd;
    end_req = end_req + 1;
    for (int i = 0; i < 20 && end_done != end_req; i++) @(posedge clk);
    if (end_done != end_req) begin
      $display("FAIL %s/end_check: monitor did not respond within 20 clks", tag);
      $fatal(1, "end check timeout");
    end
    #2;
  endtask

  initial begin
    cyc(4);
    cpu_reset = 1'b0;
    cyc(3);

    tag = "read";
    ack_dly = 0; rv_dly = 4; rdata_cfg = 16'hAB12;
    push(mk_txn(1'b0, 23'h000005, 8'h00));
    addr = 23'h000005; oe = 1'b1;
    cyc(14); oe = 1'b0; cyc(5);
    end_check(8'hAB, 0, 1, 1'b1, 22'h000002, 2'b10, 1'b0, 16'h0000);

    tag = "write";
    data_in = 8'hA3; addr = 23'h7E0010;
    push(mk_txn(1'b1, 23'h7E0010, 8'h5C));
    we = 1'b1;
    cyc(2); data_in = 8'h5C;
    cyc(12); we = 1'b0; cyc(5);
    end_check(8'hAB, 0, 1, 1'b1, 22'h3F0008, 2'b01, 1'b1, 16'h5C5C);

    tag = "long_oe";
    ack_dly = 10; rv_dly = 2; rdata_cfg = 16'h3C96;
    push(mk_txn(1'b0, 23'h000A40, 8'h00));
    addr = 23'h000A40; oe = 1'b1;
    cyc(40); oe = 1'b0; cyc(5);
    end_check(8'h96, 0, 1, 1'b1, 22'h000520, 2'b01, 1'b0, 16'h0000);

    tag = "refresh_idle";
    ack_dly = 0;
    m2 = 1'b1; cyc(6); m2 = 1'b0; cyc(6);
    end_check(8'h96, 1, 0, 1'b0, '0, 2'b00, 1'b0, 16'h0000);

    tag = "refresh_rdwait";
    m2 = 1'b1; cyc(4);
    rv_dly = 8; rdata_cfg = 16'h42E1;
    push(mk_txn(1'b0, 23'h000011, 8'h00));
    addr = 23'h000011; oe = 1'b1;
    cyc(5); m2 = 1'b0;
    cyc(1); m2 = 1'b1;
    cyc(1); m2 = 1'b0;
    cyc(10); oe = 1'b0; cyc(5);
    end_check(8'h42, 1, 1, 1'b1, 22'h000008, 2'b10, 1'b0, 16'h0000);

    tag = "oe_we_same";
    rv_dly = 1;
    data_in = 8'h77; addr = 23'h000100;
    push(mk_txn(1'b1, 23'h000100, 8'h77));
    oe = 1'b1; we = 1'b1;
    cyc(14); oe = 1'b0; we = 1'b0; cyc(5);
    end_check(8'h42, 0, 1, 1'b1, 22'h000080, 2'b01, 1'b1, 16'h7777);

    tag = "reset_abort";
    auto_ack = 1'b0;
    push(mk_txn(1'b0, 23'h000003, 8'h00));
    addr = 23'h000003; oe = 1'b1;
    cyc(6);
    cpu_reset = 1'b1;
    cyc(2); oe = 1'b0;
    cyc(1); cpu_reset = 1'b0;
    cyc(3); stray_req = stray_req + 1;
    cyc(4);
    end_check(8'h00, 0, 0, 1'b1, 22'h000000, 2'b00, 1'b0, 16'h0000);

    tag = "read_after_reset";
    auto_ack = 1'b1; rv_dly = 1; rdata_cfg = 16'h00C7;
    push(mk_txn(1'b0, 23'h000004, 8'h00));
    addr = 23'h000004; oe = 1'b1;
    cyc(10); oe = 1'b0; cyc(5);
    end_check(8'hC7, 0, 1, 1'b1, 22'h000002, 2'b01, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prg_sdram_port.md
Name: prg_sdram_port

Overview:
- Clock-domain bridge between the cartridge CPU bus and the SDRAM PRG channel. It sits directly downstream of the mapper mux.
- Takes the mux's M2-gated oe/we strobes, byte address and write data, which are asynchronous to clk.
- Converts each strobe into exactly one SDRAM word transaction with byte select and returns read data to the mux.
- Schedules SDRAM refresh requests into CPU-bus idle time.

Parameters:
- ADDR_BITS, 23, CPU-side byte address width (SDRAM word address width + 1).
- SYNC_STAGES, 2, flip-flop stages on the oe/we/m2 synchronisers, minimum 2.
- WR_SETTLE, 3, clk cycles between detecting the we rise and sampling data_in (CPU write data arrives late in M2 high).

Ports:
- clk  in  1  system clock.
- cpu_reset  in  1  asynchronous, active-high reset.
- m2  in  1  CPU M2, asynchronous.
- addr  in  ADDR_BITS  byte address from mux; stable while oe/we high.
- data_in  in  8  CPU write data.
- data_out  out  8  last completed read byte.
- oe  in  1  read strobe (M2-gated), asynchronous.
- we  in  1  write strobe (M2-gated), asynchronous.
- refresh  out  1  one-clk refresh request pulse.
- ram_req  out  1  SDRAM request, held until ram_ack.
- ram_we  out  1  1 = write, 0 = read; valid with ram_req.
- ram_addr  out  ADDR_BITS-1  word address, equal to addr[ADDR_BITS-1:1].
- ram_wmask  out  2  byte enables: bit0 = low byte (addr[0]=0), bit1 = high byte.
- ram_wdata  out  16  write byte replicated into both halves.
- ram_ack  in  1  one-clk accept of the current request.
- ram_rdata  in  16  read word.
- ram_rvalid  in  1  one-clk read data valid.

Behaviour:
- Reset values:
  - State = IDLE.
  - ram_req, ram_we, ram_wmask, refresh = 0.
  - ram_addr, ram_wdata, data_out = 0.
  - Synchronisers cleared.
- Strobe detection:
  - oe, we and m2 each pass through SYNC_STAGES flops.
  - A rising edge on synced oe or synced we starts a transaction.
  - If both rise in the same cycle, we takes priority and the read is dropped.
- FSM states: IDLE, WR_SETTLE, REQ, RD_WAIT, HOLD.
- IDLE:
  - On a synced we rise: capture addr and go to WR_SETTLE.
  - On a synced oe rise: capture addr, set ram_we=0, ram_wmask = addr[0] ? 2'b10 : 2'b01, and go to REQ.
- WR_SETTLE:
  - Count WR_SETTLE cycles.
  - On the last count: capture {data_in, data_in} into ram_wdata, set ram_we=1 and the wmask, and go to REQ.
- REQ:
  - ram_req=1 until the first cycle ram_ack=1.
  - On that cycle deassert ram_req; a write goes to HOLD, a read goes to RD_WAIT.
- RD_WAIT:
  - On ram_rvalid: data_out <= addr[0] ? ram_rdata[15:8] : ram_rdata[7:0], then go to HOLD.
  - data_out changes only here.
- HOLD:
  - Stay until both synced oe and synced we are low, then go to IDLE.
  - This guarantees one transaction per strobe.
- Latency:
  - Read: data_out is valid 1 clk after ram_rvalid.
  - From the oe pin rise this is SYNC_STAGES + 1 + SDRAM latency.
- Strobe falls early (before completion): the transaction still completes; a read still updates data_out; the FSM passes through HOLD and exits immediately.
- Refresh:
  - A synced m2 falling edge sets refresh_pending.
  - If the FSM is in IDLE or HOLD and ram_req=0, refresh pulses for 1 clk and refresh_pending clears.
  - Otherwise the pulse is deferred to the first cycle meeting that condition.
  - Refresh never pulses while ram_req=1 or while in RD_WAIT.
  - A second m2 fall while a refresh is pending does not queue another; pending stays 1.
- Stray ram_rvalid outside RD_WAIT is ignored.
- Reset mid-operation:
  - Asynchronous return to IDLE; ram_req drops immediately.
  - Any later ack/rvalid from the aborted access is ignored.
  - data_out clears to 0.
- ram_addr, ram_we and ram_wmask are held constant from REQ entry until the ack.

Decomposition:
- Shared package (fcart_pkg): the FSM state enum prg_port_state_t and the SDRAM byte-mask constants (WMASK_LO, WMASK_HI).
- One sub-module, sync_edge: a parameterised multi-stage synchroniser with rise/fall pulse outputs, used for oe, we and m2, and reusable by the chr port.

Test Plan:
- Read, addr=0x000005, ram_rdata=16'hAB12 with rvalid 4 clks after ack -> ram_addr=0x000002, ram_wmask=2'b10, exactly one ram_req, data_out=8'hAB.
- Write, addr=0x7E0010, data_in=8'h5C changing to its final value 2 clks after the we rise -> ram_we=1, ram_wdata=16'h5C5C, ram_wmask=2'b01, one request.
- oe held high 40 clks with ram_ack delayed 10 clks -> ram_req stays high until the ack, then exactly one transaction and no second request.
- m2 falls while in RD_WAIT -> refresh stays 0 until HOLD, then a single 1-clk pulse; two m2 falls before idle -> exactly one pulse.
- oe and we rise together, addr=0x000100, data_in=8'h77 -> a write only, with no read request.
- cpu_reset asserted while ram_req=1, then a late ram_rvalid with rdata=16'hFFFF -> ram_req=0 at once, data_out stays 8'h00, FSM in IDLE.
